// File: rtl/seg_display_ctrl.sv
// Multiplexed 7-segment display controller.
// Accepts a binary value over a valid/ready handshake, converts it to BCD
// (double-dabble, one bit per cycle) or slices it into hex nibbles, then
// commits all digits at once and scans them across the display with PWM dimming.
// Ports:
//   clk_100mhz, reset          - clock, async active-high reset
//   load_valid/load_ready      - value handshake; load_data, hex_mode sampled on accept
//   blank_lz, brightness,
//   dp_mask                    - live display controls
//   anode, seg, dp             - active-low display drive (registered)
//   overflow                   - last committed value exceeded NUM_DIGITS digits
module seg_display_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BRIGHT_W    = 4
) (
    input  logic                  clk_100mhz,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  overflow
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned EXT_W  = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [EXT_W-1:0] LOW_MASK = EXT_W'({BCD_W{1'b1}});

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [DATA_W-1:0]     shift_q;
    logic [BCD_W-1:0]      bcd_q, bcd_adj, disp_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  ovf_acc;
    logic [EXT_W-1:0]      hex_ext;
    logic                  hex_ovf;
    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BRIGHT_W-1:0]   pwm_cnt;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic                  cur_dp;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'h0:    seg_code = 7'b0000001;
            4'h1:    seg_code = 7'b1001111;
            4'h2:    seg_code = 7'b0010010;
            4'h3:    seg_code = 7'b0000110;
            4'h4:    seg_code = 7'b1001100;
            4'h5:    seg_code = 7'b0100100;
            4'h6:    seg_code = 7'b0100000;
            4'h7:    seg_code = 7'b0001111;
            4'h8:    seg_code = 7'b0000000;
            4'h9:    seg_code = 7'b0000100;
            4'hA:    seg_code = 7'b0001000;
            4'hB:    seg_code = 7'b1100000;
            4'hC:    seg_code = 7'b0110001;
            4'hD:    seg_code = 7'b1000010;
            4'hE:    seg_code = 7'b0110000;
            default: seg_code = 7'b0111000;
        endcase
    endfunction

    // Load FSM state register
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Load FSM next-state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_valid) state_nxt = hex_mode ? COMMIT : CONVERT;
            CONVERT: if (bit_cnt == CNT_W'(DATA_W - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready tracks the state the FSM is entering, so it equals (state == IDLE)
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) load_ready <= 1'b1;
        else       load_ready <= (state_nxt == IDLE);
    end

    // Hex path: zero-extend, flag any bit above the displayable nibbles
    assign hex_ext = EXT_W'(load_data);
    assign hex_ovf = |(hex_ext & ~LOW_MASK);

    // Add-3 correction on every BCD digit before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath and atomic commit of the display digits
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            bit_cnt  <= '0;
            ovf_acc  <= 1'b0;
            disp_q   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shift_q <= load_data;
                        bit_cnt <= '0;
                        bcd_q   <= hex_mode ? hex_ext[BCD_W-1:0] : '0;
                        ovf_acc <= hex_mode ? hex_ovf : 1'b0;
                    end
                end
                CONVERT: begin
                    bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
                    shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                    ovf_acc <= ovf_acc | bcd_adj[BCD_W-1];
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                COMMIT: begin
                    disp_q   <= bcd_q;
                    overflow <= ovf_acc;
                end
                default: ;
            endcase
        end
    end

    // Refresh slot timer, digit index and PWM counter
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            idx      <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
            if (slot_cnt == SLOT_W'(REFRESH_DIV - 1)) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    // upper_zero[i]: digit i and everything above it are zero
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (disp_q[BCD_W-1 -: 4] == 4'd0);
        for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (disp_q[4*i +: 4] == 4'd0);
        end
    end

    // Select the active digit's value, blanking and decimal point
    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        anode_sel = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit    = disp_q[4*i +: 4];
                cur_blank    = blank_lz && (i != 0) && upper_zero[i];
                cur_dp       = dp_mask[i];
                anode_sel[i] = 1'b0;
            end
        end
    end

    // Registered display drive
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            anode <= '1;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
        end else begin
            anode <= (pwm_cnt <= brightness) ? anode_sel : '1;
            seg   <= cur_blank ? 7'b1111111 : seg_code(cur_digit);
            dp    <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed loads with handshake and
// commit-timing checks, display scans compared against a scoreboard of
// expected digit patterns produced by an independent decimal/hex model.
module tb_seg_display_ctrl;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned RD = 5;
    localparam int unsigned BW = 4;

    logic          clk_100mhz = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic          hex_mode;
    logic          blank_lz;
    logic [BW-1:0] brightness;
    logic [ND-1:0] dp_mask;
    logic [ND-1:0] anode;
    logic [6:0]    seg;
    logic          dp;
    logic          overflow;

    seg_display_ctrl #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .REFRESH_DIV(RD),
        .BRIGHT_W   (BW)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .hex_mode  (hex_mode),
        .blank_lz  (blank_lz),
        .brightness(brightness),
        .dp_mask   (dp_mask),
        .anode     (anode),
        .seg       (seg),
        .dp        (dp),
        .overflow  (overflow)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct packed {
        logic [27:0] segs;
        logic [3:0]  dps;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned m_val;
    logic        m_hex;
    logic        m_ovf;

    function automatic logic [6:0] ref_seg(input int unsigned d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            10:      return 7'b0001000;
            11:      return 7'b1100000;
            12:      return 7'b0110001;
            13:      return 7'b1000010;
            14:      return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic exp_t model_exp();
        exp_t        e;
        int unsigned dig[4];
        int unsigned p;
        logic        z;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            dig[i] = m_hex ? ((m_val >> (4*i)) & 15) : ((m_val / p) % 10);
            p = p * 10;
        end
        z = 1'b1;
        e = '0;
        for (int i = 3; i >= 0; i--) begin
            z = z && (dig[i] == 0);
            e.segs[7*i +: 7] = (blank_lz && (i != 0) && z) ? 7'b1111111 : ref_seg(dig[i]);
            e.dps[i] = ~dp_mask[i];
        end
        e.ovf = m_ovf;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " load_ready"}, 32'(load_ready), 32'd1);
        chk({tag, " anode"},      32'(anode),      32'hF);
        chk({tag, " seg"},        32'(seg),        32'h7F);
        chk({tag, " dp"},         32'(dp),         32'd1);
        chk({tag, " overflow"},   32'(overflow),   32'd0);
    endtask

    // Drive one accept; check ready stays low and overflow holds until the commit edge
    task automatic do_load(input int unsigned val, input logic hx, input string tag,
                           input logic hold, input int unsigned next_val);
        int   lat;
        logic new_ovf;
        lat     = hx ? 1 : int'(DW) + 1;
        new_ovf = hx ? ((val >> (4*ND)) != 0) : (val >= 10000);
        chk({tag, " ready_pre"}, 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = DW'(val);
        hex_mode   = hx;
        step();
        if (hold) begin
            load_data = DW'(next_val);
            hex_mode  = 1'b0;
        end else begin
            load_valid = 1'b0;
            load_data  = DW'($urandom);
            hex_mode   = ~hx;
        end
        for (int j = 0; j <= lat; j++) begin
            if (j < lat) begin
                chk($sformatf("%s busy_ready j=%0d", tag, j), 32'(load_ready), 32'd0);
                chk($sformatf("%s busy_ovf j=%0d", tag, j), 32'(overflow), 32'(m_ovf));
                step();
            end else begin
                chk({tag, " ready_done"}, 32'(load_ready), 32'd1);
                chk({tag, " ovf_commit"}, 32'(overflow), 32'(new_ovf));
            end
        end
        m_val = val;
        m_hex = hx;
        m_ovf = new_ovf;
        if (!hold) sb_q.push_back(model_exp());
    endtask

    // Watch the scan for a full rotation and compare every digit against the scoreboard
    task automatic scan(input string tag);
        logic [6:0] ss[4];
        logic       dd[4];
        logic [3:0] seen;
        int         badsel;
        exp_t       e;
        seen   = '0;
        badsel = 0;
        for (int i = 0; i < 4; i++) begin
            ss[i] = 'x;
            dd[i] = 1'bx;
        end
        step();
        step();
        repeat (ND*RD*2 + 4) begin
            if ($countones(~anode) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (!anode[i]) begin
                        ss[i]   = seg;
                        dd[i]   = dp;
                        seen[i] = 1'b1;
                    end
                end
            end else begin
                badsel++;
            end
            step();
        end
        chk({tag, " onehot"}, 32'(badsel), 32'd0);
        chk({tag, " seen"},   32'(seen),   32'hF);
        total++;
        assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s seg%0d", tag, i), 32'(ss[i]), 32'(e.segs[7*i +: 7]));
                chk($sformatf("%s dp%0d", tag, i),  32'(dd[i]), 32'(e.dps[i]));
            end
            chk({tag, " overflow"}, 32'(overflow), 32'(e.ovf));
        end
    endtask

    initial begin
        int lowcnt;
        int multi;
        logic [3:0] lit;

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        hex_mode   = 1'b0;
        blank_lz   = 1'b0;
        brightness = 4'hF;
        dp_mask    = '0;
        m_val      = 0;
        m_hex      = 1'b0;
        m_ovf      = 1'b0;

        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        sb_q.push_back(model_exp());
        scan("init");

        do_load(6765, 1'b0, "dec6765", 1'b0, 0);
        scan("dec6765");
        do_load(12345, 1'b0, "dec12345", 1'b0, 0);
        scan("dec12345");
        do_load(32'hBEEF, 1'b1, "hexbeef", 1'b0, 0);
        scan("hexbeef");
        do_load(12345, 1'b0, "dec12345b", 1'b0, 0);
        scan("dec12345b");
        do_load(42, 1'b0, "dec42", 1'b0, 0);
        scan("dec42");

        blank_lz = 1'b1;
        sb_q.push_back(model_exp());
        scan("dec42_blank");
        blank_lz = 1'b0;
        sb_q.push_back(model_exp());
        scan("dec42_unblank");

        dp_mask = 4'b0101;
        sb_q.push_back(model_exp());
        scan("dp_mask");
        dp_mask = '0;

        // Minimum brightness: exactly one lit cycle per PWM period of 16
        brightness = '0;
        step();
        step();
        lowcnt = 0;
        multi  = 0;
        lit    = '0;
        repeat (160) begin
            if (anode != 4'hF) lowcnt++;
            if ($countones(~anode) > 1) multi++;
            lit = lit | ~anode;
            step();
        end
        chk("dim lowcnt", 32'(lowcnt), 32'd10);
        chk("dim multi",  32'(multi),  32'd0);
        chk("dim lit",    32'(lit),    32'hF);
        brightness = 4'hF;

        // New data offered throughout a conversion must wait for ready
        do_load(999, 1'b0, "held_a", 1'b1, 12345);
        do_load(12345, 1'b0, "held_b", 1'b0, 0);
        scan("held_b");

        // Reset during conversion cycle 5
        load_valid = 1'b1;
        load_data  = DW'(6765);
        hex_mode   = 1'b0;
        step();
        load_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset_async");
        step();
        check_reset_outputs("midreset_held");
        reset = 1'b0;
        m_val = 0;
        m_hex = 1'b0;
        m_ovf = 1'b0;
        repeat (25) step();
        chk("post_reset ready", 32'(load_ready), 32'd1);
        sb_q.push_back(model_exp());
        scan("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DATA_W, default 16, width of the loaded binary value (legal 4..32).
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, clk_100mhz cycles per digit slot (legal >= 2).
REQ-004 SHALL have parameter BRIGHT_W, default 4, width of the brightness control.
REQ-005 SHALL have port clk_100mhz, input, 1, system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port load_valid, input, 1, new value offered.
REQ-008 SHALL have port load_ready, output, 1, block can accept a value.
REQ-009 SHALL have port load_data, input, DATA_W, binary value to display.
REQ-010 SHALL have port hex_mode, input, 1, sampled with load: 1 = hexadecimal, 0 = decimal.
REQ-011 SHALL have port blank_lz, input, 1, live control: 1 = blank leading zeros.
REQ-012 SHALL have port brightness, input, BRIGHT_W, live duty-cycle control.
REQ-013 SHALL have port dp_mask, input, NUM_DIGITS, live decimal-point enables (bit i = digit i).
REQ-014 SHALL have port anode, output, NUM_DIGITS, active-low digit enables; bit 0 = rightmost (least significant) digit.
REQ-015 SHALL have port seg, output, 7, active-low segments {a,b,c,d,e,f,g}, a = MSB.
REQ-016 SHALL have port dp, output, 1, active-low decimal point.
REQ-017 SHALL have port overflow, output, 1, last committed value did not fit in NUM_DIGITS digits.

Function
REQ-018 SHALL implement load FSM states IDLE, CONVERT, COMMIT; load_ready = 1 only in IDLE.
REQ-019 SHALL accept on a rising edge with load_valid && load_ready; it SHALL capture load_data and hex_mode; load_valid outside IDLE SHALL be ignored.
REQ-020 Decimal accept: IDLE->CONVERT; one double-dabble shift-and-add-3 step per cycle over exactly DATA_W cycles; then COMMIT; COMMIT->IDLE after one cycle.
REQ-021 Hex accept: IDLE->COMMIT directly; digit i = load_data[4i+3:4i], with zero-fill above DATA_W.
REQ-022 The display digit registers SHALL update atomically on the edge leaving COMMIT: accept edge + DATA_W + 1 edges (decimal) or + 1 edge (hex); no partial value SHALL ever be displayed.
REQ-023 The BCD register SHALL hold NUM_DIGITS digits; decimal overflow = 1 iff any 1 bit is shifted out of its top during CONVERT; the display SHALL then show the low NUM_DIGITS decimal digits.
REQ-024 Hex overflow SHALL be 1 iff load_data has a nonzero bit at index >= 4*NUM_DIGITS; overflow SHALL update only at commit.
REQ-025 SHALL keep a slot counter 0..REFRESH_DIV-1; on wrap the digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-026 SHALL keep a free-running BRIGHT_W-bit PWM counter; the active digit's anode SHALL be 0 only while pwm_cnt <= brightness, otherwise all anodes SHALL be 1.
REQ-027 Segment codes (abcdefg, low = on):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
REQ-028 With blank_lz = 1, every digit above the most significant nonzero digit SHALL drive seg = 1111111; digit 0 SHALL never be blanked; dp SHALL be unaffected by blanking.
REQ-029 dp SHALL be ~dp_mask[active digit index].
REQ-030 anode, seg and dp SHALL be registered with one cycle of latency from the index/PWM state.

Reset
REQ-031 While reset is high: state = IDLE, load_ready = 1, digits = 0, overflow = 0, all counters = 0, anode = all 1, seg = 1111111, dp = 1.
REQ-032 Reset asserted mid-CONVERT SHALL abort the conversion with no commit; after release the display SHALL show all zeros.

Verification
REQ-033 Defaults, decimal load of 6765 -> load_ready low for 17 cycles; digits 6,7,6,5 committed 17 edges after accept; overflow = 0.
REQ-034 Hex load of 0xBEEF -> digits B,E,E,F committed 1 edge after accept; seg for digit 3 = 1100000.
REQ-035 Decimal load of 12345 -> overflow = 1; display 2345; a subsequent load of 42 -> overflow = 0.
REQ-036 Value 42 with blank_lz = 1 -> digits 3 and 2 show seg = 1111111; toggling blank_lz to 0 -> they show 0000001 with no reload.
REQ-037 load_valid held during CONVERT with new data -> ignored until load_ready returns; brightness = 0 -> each anode low 1 of every 16 cycles.
REQ-038 Reset pulse at CONVERT cycle 5 -> outputs match REQ-031; after release display = 0000 and load_ready = 1.
